// File: rtl/sigma_16p_sched_pkg.sv
// Shared types and constants for the 16-sample round-robin summing scheduler.
package sigma_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    OUT    = 2'd3
  } state_e;

  localparam int BEATS       = 16;
  localparam int SMP_W       = 8;
  localparam int SUM_W       = 12;
  localparam int BEAT_W      = 5;
  localparam int NCH_DEF     = 4;
  localparam int TMO_CYC_DEF = 64;

endpackage

// File: rtl/sigma_16p_sched_if.sv
// Requester, accumulator and result signals of the scheduler, bundled with directional views.
interface sigma_16p_sched_if
  import sigma_sched_pkg::*;
#(
  parameter int NCH = NCH_DEF
);
  localparam int CH_W = $clog2(NCH);

  logic [NCH-1:0]       req_valid;
  logic [NCH*SMP_W-1:0] req_data;
  logic [NCH-1:0]       req_ready;
  logic                 acc_clr;
  logic                 acc_en;
  logic [SMP_W-1:0]     acc_data;
  logic [SUM_W-1:0]     acc_sum;
  logic                 res_valid;
  logic [SUM_W-1:0]     res_data;
  logic [CH_W-1:0]      res_ch;
  logic                 res_err;
  logic                 res_ready;

  modport master (
    input  req_valid, req_data, acc_sum, res_ready,
    output req_ready, acc_clr, acc_en, acc_data, res_valid, res_data, res_ch, res_err
  );

  modport slave (
    output req_valid, req_data, acc_sum, res_ready,
    input  req_ready, acc_clr, acc_en, acc_data, res_valid, res_data, res_ch, res_err
  );

endinterface

// File: rtl/sigma_16p_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NCH = 4,
  localparam int CH_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [NCH-1:0]  gnt_o,
  output logic [CH_W-1:0] idx_o,
  output logic            any_o
);

  int unsigned cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int i = 0; i < NCH; i++) begin
      cand = (int'(ptr_i) + i) % NCH;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = CH_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sigma_16p_sched.sv
// Shares one external 16-sample accumulator among NCH requesters, one frame at a time,
// and returns each channel-tagged sum (or timed-out partial sum) on a valid/ready port.
module sigma_16p_sched
  import sigma_sched_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF,
  localparam int CH_W   = $clog2(NCH),
  localparam int IDLE_W = $clog2(TMO_CYC + 1)
) (
  input logic               clk,
  input logic               res,
  sigma_16p_sched_if.master bus
);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [NCH-1:0]      gnt_oh_q, gnt_oh_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                err_q, err_d;
  logic [SUM_W-1:0]    sum_q, sum_d;

  logic [NCH-1:0]      arb_gnt;
  logic [CH_W-1:0]     arb_idx;
  logic                arb_any;
  logic                sel_valid;
  logic [SMP_W-1:0]    sel_data;
  logic                abort;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign sel_valid = |(bus.req_valid & gnt_oh_q);
  assign sel_data  = bus.req_data[int'(grant_q)*SMP_W +: SMP_W];
  // The abort cycle itself withholds ready, so at most TMO_CYC beat-less cycles are offered.
  assign abort     = (idle_cnt_q == IDLE_W'(TMO_CYC));

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gnt_oh_d      = gnt_oh_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    err_d         = err_q;
    sum_d         = sum_q;
    bus.req_ready = '0;
    bus.acc_clr   = 1'b0;
    bus.acc_en    = 1'b0;
    bus.acc_data  = '0;
    bus.res_valid = 1'b0;
    bus.res_data  = sum_q;
    bus.res_ch    = grant_q;
    bus.res_err   = err_q;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          bus.acc_clr = 1'b1;
          grant_d     = arb_idx;
          gnt_oh_d    = arb_gnt;
          beat_cnt_d  = '0;
          idle_cnt_d  = '0;
          err_d       = 1'b0;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = DRAIN;
        end else begin
          bus.req_ready = gnt_oh_q;
          if (sel_valid) begin
            bus.acc_en   = 1'b1;
            bus.acc_data = sel_data;
            beat_cnt_d   = beat_cnt_q + 1'b1;
            idle_cnt_d   = '0;
            if (beat_cnt_q == BEAT_W'(BEATS - 1)) begin
              state_d = DRAIN;
            end
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        sum_d   = bus.acc_sum;
        state_d = OUT;
      end
      OUT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          rr_ptr_d   = (grant_q == CH_W'(NCH - 1)) ? '0 : grant_q + 1'b1;
          err_d      = 1'b0;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gnt_oh_q   <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      err_q      <= 1'b0;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gnt_oh_q   <= gnt_oh_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      err_q      <= err_d;
      sum_q      <= sum_d;
    end
  end

endmodule

// File: tb/tb_sigma_16p_sched.sv
// Directed bench for sigma_16p_sched paired with a behavioural 12-bit accumulator.
module tb_sigma_16p_sched;
  import sigma_sched_pkg::*;

  localparam int NCH = 4;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic res = 1'b0;
  int   total = 0;
  int   bad   = 0;

  sigma_16p_sched_if #(.NCH(NCH)) bus ();

  sigma_16p_sched #(.NCH(NCH), .TMO_CYC(TMO)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [11:0] acc_q;
  always_ff @(posedge clk) begin
    if (!res)             acc_q <= '0;
    else if (bus.acc_clr) acc_q <= '0;
    else if (bus.acc_en)  acc_q <= acc_q + 12'(bus.acc_data);
  end
  assign bus.acc_sum = acc_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (res) begin
      chk("ready_onehot", 32'($onehot0(bus.req_ready)), 1);
      chk("clr_en_overlap", 32'(bus.acc_clr & bus.acc_en), 0);
      chk("en_outside_stream", 32'(bus.acc_en & ~(|bus.req_ready)), 0);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_acc_clr"},   32'(bus.acc_clr), 0);
    chk({tag, "_acc_en"},    32'(bus.acc_en), 0);
    chk({tag, "_acc_data"},  32'(bus.acc_data), 0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 0);
    chk({tag, "_res_data"},  32'(bus.res_data), 0);
    chk({tag, "_res_ch"},    32'(bus.res_ch), 0);
    chk({tag, "_res_err"},   32'(bus.res_err), 0);
  endtask

  // Leaves the bench at a negedge with the DUT in IDLE and reset released.
  task automatic do_reset();
    res           = 1'b0;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    res = 1'b1;
  endtask

  task automatic wait_res(input int maxc);
    int c;
    c = 0;
    while (!bus.res_valid && c < maxc) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("res_valid_within_bound", 32'(bus.res_valid), 1);
  endtask

  task automatic chk_res(input string tag, input int ch, input int sum, input int err);
    chk({tag, "_ch"},  32'(bus.res_ch), 32'(ch));
    chk({tag, "_sum"}, 32'(bus.res_data), 32'(sum));
    chk({tag, "_err"}, 32'(bus.res_err), 32'(err));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    int c;
    int exp_ch  [5] = '{0, 1, 2, 3, 0};
    int exp_sum [5] = '{4080, 16, 32, 48, 4080};

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b1;
    @(negedge clk);

    // Test 1: ch2 alone, constant 1, exact latency
    do_reset();
    bus.req_data  = {8'd1, 8'd1, 8'd1, 8'd1};
    bus.req_valid = 4'b0100;
    #1;
    chk("t1_clr_cycle0", 32'(bus.acc_clr), 1);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      #1;
      chk("t1_no_early_res", 32'(bus.res_valid), 0);
      if (k == 1) chk("t1_ready_ch2", 32'(bus.req_ready), 32'h4);
    end
    @(negedge clk);
    #1;
    chk("t1_res_valid_c18", 32'(bus.res_valid), 1);
    chk_res("t1", 2, 16, 0);
    @(negedge clk);
    #1;
    chk("t1_idle_c19_valid", 32'(bus.res_valid), 0);
    chk("t1_idle_c19_ready", 32'(bus.req_ready), 0);
    chk("t1_rearb_c19_clr", 32'(bus.acc_clr), 1);

    // Test 2: all channels continuously, round-robin order
    do_reset();
    bus.req_data  = {8'd3, 8'd2, 8'd1, 8'd255};
    bus.req_valid = 4'hF;
    for (int f = 0; f < 5; f++) begin
      wait_res(40);
      chk_res("t2", exp_ch[f], exp_sum[f], 0);
      @(negedge clk);
      #1;
    end

    // Test 3: ch1 toggles valid every cycle
    do_reset();
    bus.req_data  = {8'd0, 8'd0, 8'd5, 8'd0};
    bus.req_valid = 4'b0010;
    beats = 0;
    c = 0;
    #1;
    while (!bus.res_valid && c < 100) begin
      @(negedge clk);
      bus.req_valid[1] = ~bus.req_valid[1];
      #1;
      if (bus.req_valid[1] && bus.req_ready[1]) beats++;
      c++;
    end
    chk("t3_beats", 32'(beats), 16);
    chk("t3_res_valid", 32'(bus.res_valid), 1);
    chk_res("t3", 1, 80, 0);
    bus.req_valid = '0;
    @(negedge clk);

    // Test 3b: grant with zero beats, timeout timing
    do_reset();
    bus.req_valid = 4'b0010;
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk("t3b_ready_ch1", 32'(bus.req_ready), 32'h2);
    for (int k = 2; k <= TMO + 2; k++) begin
      @(negedge clk);
      #1;
      chk("t3b_no_early_res", 32'(bus.res_valid), 0);
    end
    @(negedge clk);
    #1;
    chk("t3b_res_valid", 32'(bus.res_valid), 1);
    chk_res("t3b", 1, 0, 1);
    @(negedge clk);

    // Test 4: ch3 gives 3 beats of 10, then stalls into timeout
    do_reset();
    bus.req_data  = {8'd10, 8'd0, 8'd0, 8'd0};
    bus.req_valid = 4'b1000;
    beats = 0;
    c = 0;
    #1;
    while (!bus.res_valid && c < 200) begin
      if (beats == 3) bus.req_valid[3] = 1'b0;
      else if (bus.req_valid[3] && bus.req_ready[3]) beats++;
      @(negedge clk);
      #1;
      c++;
    end
    chk("t4_res_valid", 32'(bus.res_valid), 1);
    chk_res("t4", 3, 30, 1);
    @(negedge clk);

    // Test 5: next winner is ch0 (pointer wrapped); result held under backpressure
    bus.req_data  = {8'd3, 8'd2, 8'd1, 8'd255};
    bus.req_valid = 4'hF;
    bus.res_ready = 1'b0;
    wait_res(40);
    chk_res("t5_first", 0, 4080, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk("t5_hold_valid", 32'(bus.res_valid), 1);
      chk_res("t5_hold", 0, 4080, 0);
      chk("t5_hold_ready", 32'(bus.req_ready), 0);
      chk("t5_hold_en", 32'(bus.acc_en), 0);
      chk("t5_hold_clr", 32'(bus.acc_clr), 0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    #1;
    wait_res(40);
    chk_res("t5_next", 1, 16, 0);
    @(negedge clk);

    // Test 6: reset at beat 8 discards frame; pointer returns to ch0
    do_reset();
    bus.req_data  = {8'd7, 8'd7, 8'd7, 8'd7};
    bus.req_valid = 4'b0010;
    wait_res(40);
    chk_res("t6_pre", 1, 112, 0);
    @(negedge clk);
    bus.req_valid = 4'b1000;
    beats = 0;
    c = 0;
    #1;
    while (beats < 8 && c < 40) begin
      if (bus.req_valid[3] && bus.req_ready[3]) beats++;
      @(negedge clk);
      #1;
      c++;
    end
    chk("t6_reached_beat8", 32'(beats), 8);
    res           = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    chk_reset_outputs("t6_midframe");
    res = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("t6_no_result", 32'(bus.res_valid), 0);
    end
    bus.req_data  = {8'd9, 8'd9, 8'd9, 8'd3};
    bus.req_valid = 4'hF;
    wait_res(40);
    chk_res("t6_after", 0, 48, 0);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
